// File: rtl/mips_pipe_pkg.sv
// Shared widths and ID/EX control-field layout for the MIPS inter-stage latches.
package mips_pipe_pkg;

    localparam int IF_ID_DATA_BITS  = 64;
    localparam int IF_ID_CTRL_BITS  = 1;
    localparam int ID_EX_DATA_BITS  = 128;
    localparam int ID_EX_CTRL_BITS  = 24;
    localparam int EX_MEM_DATA_BITS = 106;
    localparam int EX_MEM_CTRL_BITS = 12;
    localparam int MEM_WB_DATA_BITS = 101;
    localparam int MEM_WB_CTRL_BITS = 8;

    localparam int OCC_BITS = 2;

    localparam int IDEX_REG_DST_RD   = 0;
    localparam int IDEX_JUMP         = 1;
    localparam int IDEX_JAL          = 2;
    localparam int IDEX_ALU_SRC      = 3;
    localparam int IDEX_ALU_OP       = 4;
    localparam int IDEX_BRANCH       = 6;
    localparam int IDEX_NEQ_BRANCH   = 7;
    localparam int IDEX_MEM_WRITE    = 8;
    localparam int IDEX_MEM_READ     = 9;
    localparam int IDEX_DATAMEM_SIZE = 10;
    localparam int IDEX_MEM_TO_REG   = 12;
    localparam int IDEX_REG_WRITE    = 13;
    localparam int IDEX_SIZE_FILTERL = 14;
    localparam int IDEX_ZERO_EXTEND  = 16;
    localparam int IDEX_LUI          = 17;
    localparam int IDEX_JALR         = 18;
    localparam int IDEX_HALT         = 19;

    typedef struct packed {
        logic       reg_dst_rd;
        logic       jump;
        logic       jal;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       branch;
        logic       neq_branch;
        logic       mem_write;
        logic       mem_read;
        logic [1:0] datamem_size;
        logic       mem_to_reg;
        logic       reg_write;
        logic [1:0] size_filterl;
        logic       zero_extend;
        logic       lui;
        logic       jalr;
        logic       halt;
    } id_ex_ctrl_t;

    // Upper spare bits stay zero so a bubble and an all-off decode look identical.
    function automatic logic [ID_EX_CTRL_BITS-1:0] pack_id_ex_ctrl(input id_ex_ctrl_t c);
        logic [ID_EX_CTRL_BITS-1:0] v;
        v = '0;
        v[IDEX_REG_DST_RD]          = c.reg_dst_rd;
        v[IDEX_JUMP]                = c.jump;
        v[IDEX_JAL]                 = c.jal;
        v[IDEX_ALU_SRC]             = c.alu_src;
        v[IDEX_ALU_OP +: 2]         = c.alu_op;
        v[IDEX_BRANCH]              = c.branch;
        v[IDEX_NEQ_BRANCH]          = c.neq_branch;
        v[IDEX_MEM_WRITE]           = c.mem_write;
        v[IDEX_MEM_READ]            = c.mem_read;
        v[IDEX_DATAMEM_SIZE +: 2]   = c.datamem_size;
        v[IDEX_MEM_TO_REG]          = c.mem_to_reg;
        v[IDEX_REG_WRITE]           = c.reg_write;
        v[IDEX_SIZE_FILTERL +: 2]   = c.size_filterl;
        v[IDEX_ZERO_EXTEND]         = c.zero_extend;
        v[IDEX_LUI]                 = c.lui;
        v[IDEX_JALR]                = c.jalr;
        v[IDEX_HALT]                = c.halt;
        return v;
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One {valid, ctrl, data} pipeline entry; flush beats load, load beats clear.
module pipe_entry_reg #(
    parameter int DATA_BITS = 128,
    parameter int CTRL_BITS = 24
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_load,
    input  logic                 i_clear,
    input  logic                 i_flush,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic [CTRL_BITS-1:0] i_ctrl,
    output logic                 o_valid,
    output logic [DATA_BITS-1:0] o_data,
    output logic [CTRL_BITS-1:0] o_ctrl
);

    logic                 valid_q, valid_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [CTRL_BITS-1:0] ctrl_q, ctrl_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (i_flush) begin
            valid_d = 1'b0;
            data_d  = '0;
            ctrl_d  = '0;
        end else if (i_load) begin
            valid_d = 1'b1;
            data_d  = i_data;
            ctrl_d  = i_ctrl;
        end else if (i_clear) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_ctrl  = ctrl_q;

endmodule

// File: rtl/pipe_stage_latch.sv
// Generic inter-stage latch: valid/ready handshake, optional 2-entry skid, flush, flush counter.
module pipe_stage_latch
    import mips_pipe_pkg::*;
#(
    parameter int DATA_BITS = 128,
    parameter int CTRL_BITS = 24,
    parameter bit SKID_EN   = 1'b1,
    parameter int CNT_BITS  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_step,
    input  logic                 i_flush,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic [CTRL_BITS-1:0] i_ctrl,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [DATA_BITS-1:0] o_data,
    output logic [CTRL_BITS-1:0] o_ctrl,
    output logic [OCC_BITS-1:0]  o_occupancy,
    output logic [CNT_BITS-1:0]  o_flush_count
);

    logic                 m_valid, s_valid;
    logic [DATA_BITS-1:0] m_data, s_data, m_src_data;
    logic [CTRL_BITS-1:0] m_ctrl, s_ctrl, m_src_ctrl;
    logic                 m_load, m_clear, s_load, s_clear;
    logic                 in_fire, out_fire;
    logic [CNT_BITS-1:0]  flush_cnt_q, flush_cnt_d;

    assign in_fire  = i_valid & o_ready & i_step;
    assign out_fire = m_valid & i_ready & i_step;

    // Skid mode keeps ready purely registered so it never depends on downstream ready.
    assign o_ready = SKID_EN ? !s_valid : (!m_valid || (i_ready && i_step));

    always_comb begin
        m_load  = 1'b0;
        m_clear = 1'b0;
        s_load  = 1'b0;
        s_clear = 1'b0;
        if (i_step) begin
            if (SKID_EN) begin
                if (out_fire || !m_valid) begin
                    if (s_valid) begin
                        m_load  = 1'b1;
                        s_clear = 1'b1;
                    end else if (in_fire) begin
                        m_load  = 1'b1;
                    end else begin
                        m_clear = 1'b1;
                    end
                end else if (in_fire) begin
                    s_load = 1'b1;
                end
            end else begin
                if (in_fire) begin
                    m_load  = 1'b1;
                end else if (out_fire) begin
                    m_clear = 1'b1;
                end
            end
        end
    end

    // The older skid entry always drains into M before new input does.
    assign m_src_data = s_valid ? s_data : i_data;
    assign m_src_ctrl = s_valid ? s_ctrl : i_ctrl;

    pipe_entry_reg #(
        .DATA_BITS(DATA_BITS),
        .CTRL_BITS(CTRL_BITS)
    ) u_main (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_load    (m_load),
        .i_clear   (m_clear),
        .i_flush   (i_flush),
        .i_data    (m_src_data),
        .i_ctrl    (m_src_ctrl),
        .o_valid   (m_valid),
        .o_data    (m_data),
        .o_ctrl    (m_ctrl)
    );

    generate
        if (SKID_EN) begin : g_skid
            pipe_entry_reg #(
                .DATA_BITS(DATA_BITS),
                .CTRL_BITS(CTRL_BITS)
            ) u_skid (
                .i_clk     (i_clk),
                .i_reset_n (i_reset_n),
                .i_load    (s_load),
                .i_clear   (s_clear),
                .i_flush   (i_flush),
                .i_data    (i_data),
                .i_ctrl    (i_ctrl),
                .o_valid   (s_valid),
                .o_data    (s_data),
                .o_ctrl    (s_ctrl)
            );
        end else begin : g_no_skid
            assign s_valid = 1'b0;
            assign s_data  = '0;
            assign s_ctrl  = '0;
        end
    endgenerate

    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if (i_flush && (flush_cnt_q != {CNT_BITS{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_BITS'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            flush_cnt_q <= '0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_valid       = m_valid;
    assign o_data        = m_data;
    assign o_ctrl        = m_valid ? m_ctrl : '0;
    assign o_occupancy   = OCC_BITS'(m_valid) + OCC_BITS'(s_valid);
    assign o_flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Bench for pipe_stage_latch: skid and non-skid instances checked against queue models.
module tb_pipe_stage_latch;

    localparam int DW = 128;
    localparam int CW = 24;

    typedef struct {
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
    } ent_t;

    logic          i_clk = 1'b0;
    logic          i_reset_n = 1'b0;
    logic          i_step = 1'b0;
    logic          i_flush = 1'b0;
    logic          i_valid = 1'b0;
    logic          i_ready = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic [CW-1:0] i_ctrl = '0;

    logic          a_ready, a_valid, b_ready, b_valid;
    logic [DW-1:0] a_data, b_data;
    logic [CW-1:0] a_ctrl, b_ctrl;
    logic [1:0]    a_occ, b_occ;
    logic [15:0]   a_cnt;
    logic [1:0]    b_cnt;

    int            total = 0;
    int            bad = 0;
    ent_t          qa[$];
    ent_t          qb[$];
    logic [DW-1:0] held_a = '0;
    logic [DW-1:0] held_b = '0;
    int            fcnt = 0;

    always #5 i_clk = ~i_clk;

    pipe_stage_latch #(
        .DATA_BITS(DW), .CTRL_BITS(CW), .SKID_EN(1'b1), .CNT_BITS(16)
    ) dut_a (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_step(i_step), .i_flush(i_flush),
        .i_valid(i_valid), .o_ready(a_ready), .i_data(i_data), .i_ctrl(i_ctrl),
        .o_valid(a_valid), .i_ready(i_ready), .o_data(a_data), .o_ctrl(a_ctrl),
        .o_occupancy(a_occ), .o_flush_count(a_cnt)
    );

    pipe_stage_latch #(
        .DATA_BITS(DW), .CTRL_BITS(CW), .SKID_EN(1'b0), .CNT_BITS(2)
    ) dut_b (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_step(i_step), .i_flush(i_flush),
        .i_valid(i_valid), .o_ready(b_ready), .i_data(i_data), .i_ctrl(i_ctrl),
        .o_valid(b_valid), .i_ready(i_ready), .o_data(b_data), .o_ctrl(b_ctrl),
        .o_occupancy(b_occ), .o_flush_count(b_cnt)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [CW-1:0] ec_a, ec_b;
        int            ea_cnt, eb_cnt;
        ec_a   = (qa.size() != 0) ? qa[0].ctrl : '0;
        ec_b   = (qb.size() != 0) ? qb[0].ctrl : '0;
        ea_cnt = (fcnt > 65535) ? 65535 : fcnt;
        eb_cnt = (fcnt > 3) ? 3 : fcnt;
        chk("a_ready", DW'(a_ready), DW'(qa.size() < 2));
        chk("a_valid", DW'(a_valid), DW'(qa.size() != 0));
        chk("a_data",  a_data, held_a);
        chk("a_ctrl",  DW'(a_ctrl), DW'(ec_a));
        chk("a_occ",   DW'(a_occ), DW'(qa.size()));
        chk("a_cnt",   DW'(a_cnt), DW'(ea_cnt));
        chk("b_ready", DW'(b_ready), DW'((qb.size() == 0) || (i_ready && i_step)));
        chk("b_valid", DW'(b_valid), DW'(qb.size() != 0));
        chk("b_data",  b_data, held_b);
        chk("b_ctrl",  DW'(b_ctrl), DW'(ec_b));
        chk("b_occ",   DW'(b_occ), DW'(qb.size()));
        chk("b_cnt",   DW'(b_cnt), DW'(eb_cnt));
    endtask

    // Each instance is a bounded FIFO; acceptance depends only on its fill level and the handshake.
    task automatic model_edge();
        ent_t e;
        bit   a_in, a_out, b_in, b_out;
        e.data = i_data;
        e.ctrl = i_ctrl;
        a_out = (qa.size() != 0) && i_ready && i_step;
        a_in  = i_valid && (qa.size() < 2) && i_step;
        b_out = (qb.size() != 0) && i_ready && i_step;
        b_in  = i_valid && ((qb.size() == 0) || (i_ready && i_step)) && i_step;
        if (i_flush) begin
            qa.delete();
            qb.delete();
            held_a = '0;
            held_b = '0;
            fcnt++;
        end else begin
            if (a_out) void'(qa.pop_front());
            if (a_in) qa.push_back(e);
            if (qa.size() != 0) held_a = qa[0].data;
            if (b_out) void'(qb.pop_front());
            if (b_in) qb.push_back(e);
            if (qb.size() != 0) held_b = qb[0].data;
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        held_a = '0;
        held_b = '0;
        fcnt   = 0;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r,
                         input logic s, input logic f);
        i_valid = v;
        i_data  = d;
        i_ctrl  = d[CW-1:0] ^ 24'h5a5a5a;
        i_ready = r;
        i_step  = s;
        i_flush = f;
    endtask

    task automatic tick();
        #1;
        check_all();
        model_edge();
        @(negedge i_clk);
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        i_reset_n = 1'b0;
        repeat (2) @(negedge i_clk);
        #1;
        check_all();
        i_reset_n = 1'b1;
        @(negedge i_clk);

        // Streaming at full rate.
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, DW'(k), 1'b1, 1'b1, 1'b0);
            tick();
            chk("stream_data", a_data, DW'(k));
            chk("stream_occ", DW'(a_occ), DW'(1));
        end
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
        tick();
        chk("drain_valid", DW'(a_valid), DW'(0));
        chk("drain_hold", a_data, DW'(4));

        // Back-pressure into the skid entry.
        drive(1'b1, DW'('hA), 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, DW'('hB), 1'b0, 1'b1, 1'b0);
        tick();
        chk("full_occ", DW'(a_occ), DW'(2));
        chk("full_ready", DW'(a_ready), DW'(0));
        drive(1'b1, DW'('hD), 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
        #1;
        chk("bp_first", a_data, DW'('hA));
        tick();
        chk("bp_second", a_data, DW'('hB));
        chk("bp_ready_back", DW'(a_ready), DW'(1));
        tick();
        chk("bp_empty", DW'(a_valid), DW'(0));

        // Flush at occupancy 2 with a new input offered.
        drive(1'b1, DW'(5), 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, DW'(6), 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, DW'('hC), 1'b1, 1'b1, 1'b1);
        tick();
        chk("flush_valid", DW'(a_valid), DW'(0));
        chk("flush_ctrl", DW'(a_ctrl), DW'(0));
        chk("flush_data", a_data, DW'(0));
        chk("flush_occ", DW'(a_occ), DW'(0));
        chk("flush_cnt", DW'(a_cnt), DW'(1));
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
        tick();
        chk("flush_no_c", a_data, DW'(0));

        // Step gating.
        drive(1'b1, DW'('h20), 1'b0, 1'b1, 1'b0);
        tick();
        repeat (3) begin
            drive(1'b1, DW'('h21), 1'b1, 1'b0, 1'b0);
            tick();
            chk("frozen_data", a_data, DW'('h20));
            chk("frozen_occ", DW'(a_occ), DW'(1));
        end
        drive(1'b1, DW'('h22), 1'b1, 1'b1, 1'b0);
        tick();
        chk("step_one_xfer", a_data, DW'('h22));
        chk("step_occ", DW'(a_occ), DW'(1));
        drive(1'b1, DW'('h23), 1'b1, 1'b0, 1'b1);
        tick();
        chk("flush_nostep_occ", DW'(a_occ), DW'(0));
        chk("flush_nostep_cnt", DW'(a_cnt), DW'(2));

        // Asynchronous reset while full.
        drive(1'b1, DW'('h30), 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, DW'('h31), 1'b0, 1'b1, 1'b0);
        tick();
        chk("pre_rst_occ", DW'(a_occ), DW'(2));
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("rst_valid", DW'(a_valid), DW'(0));
        chk("rst_data", a_data, DW'(0));
        chk("rst_ctrl", DW'(a_ctrl), DW'(0));
        chk("rst_occ", DW'(a_occ), DW'(0));
        chk("rst_cnt", DW'(a_cnt), DW'(0));
        chk("rst_b_valid", DW'(b_valid), DW'(0));
        chk("rst_b_cnt", DW'(b_cnt), DW'(0));
        model_reset();
        @(negedge i_clk);
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
        i_reset_n = 1'b1;
        tick();

        // Counter saturation on the narrow instance.
        repeat (5) begin
            drive(1'b0, '0, 1'b1, 1'b1, 1'b1);
            tick();
        end
        chk("sat_b_cnt", DW'(b_cnt), DW'(3));
        chk("sat_a_cnt", DW'(a_cnt), DW'(5));

        // Non-skid ready follows downstream ready in the same cycle.
        drive(1'b1, DW'('h40), 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, DW'('h41), 1'b1, 1'b1, 1'b0);
        #1;
        chk("noskid_valid", DW'(b_valid), DW'(1));
        chk("noskid_ready", DW'(b_ready), DW'(1));
        tick();
        chk("noskid_next", b_data, DW'('h41));

        // Randomized traffic.
        repeat (400) begin
            drive(1'($urandom_range(0, 3) != 0),
                  {$urandom, $urandom, $urandom, $urandom},
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 7) != 0),
                  1'($urandom_range(0, 24) == 0));
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        #1;
        check_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
